// File: rtl/face_filter_pkg.sv
// Shared types and constants for the UART bounding-box decoder.
package face_filter_pkg;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned FIELD_W      = 16;
  localparam int unsigned BBOX_PKT_LEN = 11;

  localparam logic [7:0] BBOX_SYNC    = 8'hA5;
  localparam logic [7:0] BBOX_CMD_CLR = 8'h00;
  localparam logic [7:0] BBOX_CMD_SET = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_CKSUM
  } bbox_state_e;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x_start;
    logic [COORD_W-1:0] x_end;
    logic [COORD_W-1:0] y_start;
    logic [COORD_W-1:0] y_end;
  } bbox_t;

endpackage

// File: rtl/bbox_clamp.sv
// Combinational range check and edge clamp of a received X/Y/W/H box.
module bbox_clamp
  import face_filter_pkg::*;
#(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480
) (
  input  logic [FIELD_W-1:0] x,
  input  logic [FIELD_W-1:0] y,
  input  logic [FIELD_W-1:0] w,
  input  logic [FIELD_W-1:0] h,
  output bbox_t              box_c,
  output logic               valid_c
);

  localparam int unsigned SUM_W = FIELD_W + 1;
  localparam logic [SUM_W-1:0] H_LIM = SUM_W'(H_ACT);
  localparam logic [SUM_W-1:0] V_LIM = SUM_W'(V_ACT);

  logic [SUM_W-1:0] x_sum;
  logic [SUM_W-1:0] y_sum;
  logic [SUM_W-1:0] x_lim;
  logic [SUM_W-1:0] y_lim;

  // Sums are one bit wider than the fields so huge W/H clamp instead of wrapping.
  always_comb begin
    x_sum   = SUM_W'(x) + SUM_W'(w);
    y_sum   = SUM_W'(y) + SUM_W'(h);
    x_lim   = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_lim   = (y_sum > V_LIM) ? V_LIM : y_sum;
    valid_c = (SUM_W'(x) < H_LIM) && (SUM_W'(y) < V_LIM) &&
              (w != '0) && (h != '0);
    box_c.en      = 1'b1;
    box_c.x_start = COORD_W'(x);
    box_c.x_end   = COORD_W'(x_lim - SUM_W'(1));
    box_c.y_start = COORD_W'(y);
    box_c.y_end   = COORD_W'(y_lim - SUM_W'(1));
  end

endmodule

// File: rtl/uart_bbox_decoder.sv
// Parses 11-byte bounding-box packets from the UART receiver and presents a
// frame-synchronous box to the overlay. Optional inter-byte timeout is built
// when BBOX_TIMEOUT_EN is defined.
module uart_bbox_decoder
  import face_filter_pkg::*;
#(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480
`ifdef BBOX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 17400
`endif
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  input  logic       iFRAME_SYNC,
  output logic       oBOX_EN,
  output logic [9:0] oX_START,
  output logic [9:0] oX_END,
  output logic [9:0] oY_START,
  output logic [9:0] oY_END,
  output logic       oPKT_OK,
  output logic       oERR,
  output logic [7:0] oERR_CNT
);

  localparam int unsigned DATA_LEN = BBOX_PKT_LEN - 3;
  localparam int unsigned FIELDS_W = DATA_LEN * 8;
  localparam int unsigned IDX_W    = $clog2(DATA_LEN);
  localparam int unsigned CNT_W    = 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bbox_state_e         state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [FIELDS_W-1:0] fields_q, fields_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          xor_q, xor_d;
  bbox_t               pend_q, pend_d;
  bbox_t               act_q;
  logic                pkt_ok_q, pkt_ok_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q;

  bbox_t               box_c;
  logic                box_valid_c;
  logic                cmd_ok_c;

  bbox_clamp #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT)
  ) u_clamp (
    .x       (fields_q[4*FIELD_W-1 -: FIELD_W]),
    .y       (fields_q[3*FIELD_W-1 -: FIELD_W]),
    .w       (fields_q[2*FIELD_W-1 -: FIELD_W]),
    .h       (fields_q[1*FIELD_W-1 -: FIELD_W]),
    .box_c   (box_c),
    .valid_c (box_valid_c)
  );

  assign cmd_ok_c = (cmd_q == BBOX_CMD_CLR) ||
                    ((cmd_q == BBOX_CMD_SET) && box_valid_c);

`ifdef BBOX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit_c;

  // Cycles since the last byte while a packet is in progress.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                             tmo_q <= '0;
    else if (state_q == ST_IDLE || iRX_VALID) tmo_q <= '0;
    else                                     tmo_q <= tmo_q + TMO_W'(1);
  end

  assign tmo_hit_c = (state_q != ST_IDLE) && !iRX_VALID && (tmo_q == TMO_LAST);
`else
  logic tmo_hit_c;
  assign tmo_hit_c = 1'b0;
`endif

  // Parser next state; the checksum byte decides accept or reject.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    fields_d = fields_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    pend_d   = pend_q;
    pkt_ok_d = 1'b0;
    err_d    = 1'b0;
    if (iRX_VALID) begin
      case (state_q)
        ST_IDLE: begin
          if (iRX_DATA == BBOX_SYNC) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_d   = iRX_DATA;
          xor_d   = iRX_DATA;
          idx_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          fields_d = {fields_q[FIELDS_W-9:0], iRX_DATA};
          xor_d    = xor_q ^ iRX_DATA;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_CKSUM;
        end
        ST_CKSUM: begin
          state_d = ST_IDLE;
          if (cmd_ok_c && (iRX_DATA == xor_q)) begin
            pkt_ok_d = 1'b1;
            pend_d   = (cmd_q == BBOX_CMD_SET) ? box_c : '0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit_c) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  // Parser state, field capture, pending/active boxes and status pulses.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      fields_q  <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      pend_q    <= '0;
      act_q     <= '0;
      pkt_ok_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      fields_q <= fields_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      pend_q   <= pend_d;
      pkt_ok_q <= pkt_ok_d;
      err_q    <= err_d;
      if (iFRAME_SYNC) act_q <= pend_q;
      if (err_d && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign oBOX_EN  = act_q.en;
  assign oX_START = act_q.x_start;
  assign oX_END   = act_q.x_end;
  assign oY_START = act_q.y_start;
  assign oY_END   = act_q.y_end;
  assign oPKT_OK  = pkt_ok_q;
  assign oERR     = err_q;
  assign oERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_uart_bbox_decoder.sv
// Randomized bench for uart_bbox_decoder against a packet-level reference model.
module tb_uart_bbox_decoder;
  import face_filter_pkg::*;

  localparam int TMO  = 17400;
  localparam int HACT = 640;
  localparam int VACT = 480;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iRX_DATA = 8'h00;
  logic       iRX_VALID = 1'b0;
  logic       iFRAME_SYNC = 1'b0;
  logic       oBOX_EN;
  logic [9:0] oX_START, oX_END, oY_START, oY_END;
  logic       oPKT_OK, oERR;
  logic [7:0] oERR_CNT;

  uart_bbox_decoder dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iRX_DATA    (iRX_DATA),
    .iRX_VALID   (iRX_VALID),
    .iFRAME_SYNC (iFRAME_SYNC),
    .oBOX_EN     (oBOX_EN),
    .oX_START    (oX_START),
    .oX_END      (oX_END),
    .oY_START    (oY_START),
    .oY_END      (oY_END),
    .oPKT_OK     (oPKT_OK),
    .oERR        (oERR),
    .oERR_CNT    (oERR_CNT)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_bad = 0;

  bbox_t      m_pend = '0;
  bbox_t      m_act  = '0;
  int         m_cnt  = 0;
  logic [7:0] pkt [BBOX_PKT_LEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("box_en",  32'(oBOX_EN),  32'(m_act.en));
    check("x_start", 32'(oX_START), 32'(m_act.x_start));
    check("x_end",   32'(oX_END),   32'(m_act.x_end));
    check("y_start", 32'(oY_START), 32'(m_act.y_start));
    check("y_end",   32'(oY_END),   32'(m_act.y_end));
    check("err_cnt", 32'(oERR_CNT), 32'(m_cnt));
  endtask

  task automatic build(input logic [7:0] cmd, input int x, input int y,
                       input int w, input int h, input bit bad_cks);
    logic [7:0] c;
    pkt[0] = BBOX_SYNC;  pkt[1] = cmd;
    pkt[2] = 8'(x >> 8); pkt[3] = 8'(x);
    pkt[4] = 8'(y >> 8); pkt[5] = 8'(y);
    pkt[6] = 8'(w >> 8); pkt[7] = 8'(w);
    pkt[8] = 8'(h >> 8); pkt[9] = 8'(h);
    c = 8'h00;
    for (int i = 1; i <= 9; i++) c = c ^ pkt[i];
    pkt[10] = bad_cks ? (c ^ 8'h01) : c;
  endtask

  // Expected outcome of the packet in pkt[], from the packet rules alone.
  task automatic eval(output bit ok, output bbox_t nb);
    int x, y, w, h, xe, ye;
    logic [7:0] c;
    x = int'({pkt[2], pkt[3]}); y = int'({pkt[4], pkt[5]});
    w = int'({pkt[6], pkt[7]}); h = int'({pkt[8], pkt[9]});
    c = 8'h00;
    for (int i = 1; i <= 9; i++) c = c ^ pkt[i];
    ok = (c == pkt[10]) &&
         ((pkt[1] == 8'h00) ||
          (pkt[1] == 8'h01 && x < HACT && y < VACT && w > 0 && h > 0));
    nb = '0;
    if (ok && pkt[1] == 8'h01) begin
      xe = ((x + w) > HACT) ? HACT : (x + w);
      ye = ((y + h) > VACT) ? VACT : (y + h);
      nb.en = 1'b1;
      nb.x_start = 10'(x); nb.x_end = 10'(xe - 1);
      nb.y_start = 10'(y); nb.y_end = 10'(ye - 1);
    end
  endtask

  // One clock with the given inputs; model updated for that edge, then compared.
  task automatic cycle(input logic v, input logic [7:0] d, input logic sync,
                       input logic exp_ok, input logic exp_err, input bbox_t nb);
    iRX_VALID = v; iRX_DATA = d; iFRAME_SYNC = sync;
    @(posedge iCLK); #1;
    iRX_VALID = 1'b0; iFRAME_SYNC = 1'b0;
    if (sync) m_act = m_pend;
    if (exp_ok) m_pend = nb;
    if (exp_err && m_cnt < 255) m_cnt++;
    check("pkt_ok", 32'(oPKT_OK), 32'(exp_ok));
    check("err",    32'(oERR),    32'(exp_err));
    check_outputs();
  endtask

  task automatic send_range(input int lo, input int hi, input bit sync_last, input int gap_max);
    bit ok; bbox_t nb; bit last;
    eval(ok, nb);
    for (int i = lo; i <= hi; i++) begin
      for (int g = 0; g < int'($urandom_range(0, gap_max)); g++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      last = (i == BBOX_PKT_LEN - 1);
      cycle(1'b1, pkt[i], last && sync_last, last && ok, last && !ok, nb);
    end
  endtask

  task automatic send_pkt(input bit sync_last, input int gap_max);
    send_range(0, BBOX_PKT_LEN - 1, sync_last, gap_max);
  endtask

  task automatic frame_sync();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    #3 iRST_N = 1'b0;
    #1;
    m_pend = '0; m_act = '0; m_cnt = 0;
    check("rst_pkt_ok", 32'(oPKT_OK), 32'd0);
    check("rst_err",    32'(oERR),    32'd0);
    check_outputs();
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, x, y, w, h, n;
    logic [7:0] cmd, g;
    bit seen;

    repeat (3) @(posedge iCLK);
    #1;
    check("reset_pkt_ok", 32'(oPKT_OK), 32'd0);
    check("reset_err",    32'(oERR),    32'd0);
    check_outputs();
    iRST_N = 1'b1;
    @(posedge iCLK); #1;

    // Basic set, shown after frame sync
    build(8'h01, 100, 50, 200, 100, 1'b0);
    send_pkt(1'b0, 0);
    check("t1_not_yet", 32'(oBOX_EN), 32'd0);
    frame_sync();
    check("t1_xs", 32'(oX_START), 32'd100);
    check("t1_xe", 32'(oX_END),   32'd299);
    check("t1_ys", 32'(oY_START), 32'd50);
    check("t1_ye", 32'(oY_END),   32'd149);
    check("t1_en", 32'(oBOX_EN),  32'd1);

    // Edge clamp, then out-of-range X rejected
    build(8'h01, 600, 400, 100, 200, 1'b0);
    send_pkt(1'b0, 2);
    frame_sync();
    check("t2_xe", 32'(oX_END), 32'd639);
    check("t2_ye", 32'(oY_END), 32'd479);
    build(8'h01, 640, 0, 10, 10, 1'b0);
    send_pkt(1'b0, 1);
    check("t2_cnt", 32'(oERR_CNT), 32'd1);
    frame_sync();
    check("t2_keep", 32'(oX_START), 32'd600);

    // Bad checksum, then a good packet
    build(8'h01, 10, 20, 30, 40, 1'b1);
    send_pkt(1'b0, 1);
    frame_sync();
    build(8'h01, 10, 20, 30, 40, 1'b0);
    send_pkt(1'b0, 1);
    frame_sync();
    check("t3_xe", 32'(oX_END), 32'd39);

    // Completion coincident with frame sync
    build(8'h01, 1, 2, 3, 4, 1'b0);
    send_pkt(1'b0, 0);
    build(8'h01, 300, 200, 50, 60, 1'b0);
    send_pkt(1'b1, 0);
    check("t4_old", 32'(oX_START), 32'd1);
    frame_sync();
    check("t4_new", 32'(oX_START), 32'd300);

`ifdef BBOX_TIMEOUT_EN
    // Stall mid-packet until the timeout fires
    build(8'h01, 5, 5, 5, 5, 1'b0);
    send_range(0, 4, 1'b0, 0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < TMO + 20) begin
      @(posedge iCLK); #1;
      n++;
      seen = oERR;
    end
    check("tmo_seen", 32'(seen), 32'd1);
    check("tmo_window", 32'(n >= TMO - 2 && n <= TMO + 2), 32'd1);
    if (m_cnt < 255) m_cnt++;
    @(posedge iCLK); #1;
    check_outputs();
    build(8'h01, 7, 8, 9, 10, 1'b0);
    send_pkt(1'b0, 0);
    frame_sync();
`else
    // Long stall mid-packet; packet still completes
    build(8'h01, 5, 5, 5, 5, 1'b0);
    send_range(0, 4, 1'b0, 0);
    repeat (600) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    send_range(5, BBOX_PKT_LEN - 1, 1'b0, 0);
    frame_sync();
    check("stall_xs", 32'(oX_START), 32'd5);
`endif

    // Garbage in idle is silently discarded
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, '0);

    // Randomized packets with garbage, gaps and frame syncs
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == BBOX_SYNC) g = 8'h5A;
        cycle(1'b1, g, 1'b0, 1'b0, 1'b0, '0);
      end
      r = int'($urandom_range(0, 9));
      cmd = (r == 0) ? 8'h00 : (r == 1) ? 8'($urandom_range(0, 255)) : 8'h01;
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 520));
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60000, 65535)) : int'($urandom_range(0, 300));
      h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60000, 65535)) : int'($urandom_range(0, 300));
      build(cmd, x, y, w, h, $urandom_range(0, 7) == 0);
      send_pkt($urandom_range(0, 3) == 0, 2);
      if ($urandom_range(0, 1) == 0) frame_sync();
    end

    // Error counter saturation
    for (int k = 0; k < 256; k++) begin
      build(8'h07, 1, 1, 1, 1, 1'b0);
      send_pkt(1'b0, 0);
    end
    check("sat_cnt", 32'(oERR_CNT), 32'd255);

    // Reset mid-packet drops the partial packet
    build(8'h01, 20, 30, 40, 50, 1'b0);
    send_range(0, 4, 1'b0, 0);
    do_reset();
    check("rst_cnt", 32'(oERR_CNT), 32'd0);
    build(8'h01, 20, 30, 40, 50, 1'b0);
    send_pkt(1'b0, 0);
    frame_sync();
    check("rst_after", 32'(oY_END), 32'd79);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
